bb_header_parser: RTL and testbench
===================================

Name: bb_header_parser

Overview:
- DVB-S2 receive-chain stage directly downstream of the baseband descrambler.
- Consumes the descrambled serial BBFRAME of K_BCH bits, one bit per valid cycle, MSB first.
- Extracts and CRC-8 checks the 80-bit BBHEADER and exposes its fields.
- Forwards the DFL data-field bits to the next stage and discards the padding.

Parameters:
- HDR_BITS, 80, BBHEADER length in bits (72 field bits + 8 CRC bits).
- K_WIDTH, 16, width of K_BCH and of the frame bit counter.
- CRC_POLY, 8'hD5, CRC-8 generator x^8+x^7+x^6+x^4+x^2+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- bit_stream_in  in  1  descrambled frame bit.
- valid_in  in  1  bit_stream_in qualifier.
- K_BCH  in  16  frame length in bits.
- hdr_valid  out  1  one-cycle pulse: header fields below are updated.
- crc_ok  out  1  CRC result of the last header, held until the next header.
- dfl_err  out  1  DFL exceeded K_BCH-80 in the last header.
- matype  out  16  MATYPE field (header bits 0..15).
- upl  out  16  UPL field (bits 16..31).
- dfl  out  16  DFL field (bits 32..47), unclamped.
- sync  out  8  SYNC field (bits 48..55).
- syncd  out  16  SYNCD field (bits 56..71).
- data_out  out  1  data-field bit.
- data_valid  out  1  data_out qualifier.
- frame_end  out  1  one-cycle pulse after the last bit of a frame is consumed.

Behaviour:
- Reset (rst=0, async): every output is 0; counter = 0; state = HDR; CRC register = 0.
- Bits are consumed only when valid_in=1. With valid_in=0, all state holds, and data_valid, hdr_valid and frame_end are 0.
- At counter = 0, K_BCH is latched as frame length L. If K_BCH < 80, L = 80.
- State HDR (counter 0..79):
  - Each bit shifts into an 80-bit register.
  - Bits 0..71 update the serial CRC: fb = crc[7]^bit; crc = {crc[6:0],1'b0} ^ (fb ? CRC_POLY : 0); init 0.
  - On bit 79, the next cycle: fields registered, hdr_valid=1, crc_ok = (received byte == crc), dfl_err = (dfl > L-80).
  - Effective data length E = min(dfl, L-80).
- State DATA (counter 80..80+E-1):
  - If crc_ok=1: data_out = bit, data_valid=1, one cycle after acceptance.
  - If crc_ok=0: bits are dropped and data_valid stays 0.
  - If E = 0, go straight to PAD (or finish).
- State PAD (remaining bits to L-1): bits are discarded.
- Last bit (counter = L-1): next cycle frame_end=1; counter returns to 0; state returns to HDR; CRC register cleared.
- If the last bit is also a data bit, data_valid and frame_end assert in the same cycle.
- Latency: data_out is exactly 1 clk after the accepting edge. hdr_valid is 1 clk after the 80th bit.
- Counter is K_WIDTH wide and never wraps within a frame (L ≤ 65535).
- Reset mid-frame aborts the frame: no frame_end, and the next accepted bit is header bit 0.
- Field outputs hold their values between hdr_valid pulses.

Optional Feature:
- Macro BBHDR_CRC_CHECK_EN.
- Defined: CRC logic is present; crc_ok is as above; data of failing frames is suppressed.
- Undefined: no CRC logic; crc_ok is constant 1 after reset; the CRC byte is ignored; all DATA bits are forwarded.

Decomposition:
- Package bb_pkg:
  - HDR_BITS and CRC_POLY.
  - Field offset/width constants: MATYPE_OFS=0, UPL_OFS=16, DFL_OFS=32, SYNC_OFS=48, SYNCD_OFS=56, CRC_OFS=72.
  - State encoding: HDR, DATA, PAD.
- Sub-module bb_crc8_serial (clear, enable, bit in, 8-bit crc out), instantiated only under BBHDR_CRC_CHECK_EN.

Test Plan:
- All-zero 80-bit header, K_BCH=200, 120 zero pad bits:
  - hdr_valid pulses at cycle 81 with crc_ok=1, dfl=0.
  - data_valid is never asserted.
  - frame_end pulses exactly once.
- Header with dfl=40 and a CRC byte from the golden model, K_BCH=200, alternating 1010 data:
  - 40 data_valid pulses with the 1010 pattern, each 1 cycle late.
  - 80 pad bits dropped; frame_end pulses once.
- Same frame with CRC bit 79 flipped: crc_ok=0, zero data_valid pulses, frame_end still pulses.
- dfl=500 with K_BCH=200: dfl_err=1, dfl reads 500, exactly 120 data bits forwarded.
- valid_in toggling 1,0,1,0 throughout a K_BCH=200 frame: identical outputs to the gapless case, stretched in time.
- rst=0 for 1 cycle at counter=150, then a fresh frame: no frame_end for the aborted frame, and the new header parses correctly.

Source files
------------

// File: rtl/bb_header_parser_pkg.sv
// Shared constants, field layout and FSM encoding for the DVB-S2 BBHEADER parser.
package bb_pkg;
  localparam int               HDR_BITS = 80;
  localparam int               K_WIDTH  = 16;
  localparam logic [7:0]       CRC_POLY = 8'hD5;

  localparam int MATYPE_OFS = 0;
  localparam int UPL_OFS    = 16;
  localparam int DFL_OFS    = 32;
  localparam int SYNC_OFS   = 48;
  localparam int SYNCD_OFS  = 56;
  localparam int CRC_OFS    = 72;

  localparam logic [K_WIDTH-1:0] HDR_LEN  = K_WIDTH'(HDR_BITS);
  localparam logic [K_WIDTH-1:0] HDR_LAST = K_WIDTH'(HDR_BITS - 1);
  localparam logic [K_WIDTH-1:0] CRC_LEN  = K_WIDTH'(CRC_OFS);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2
  } state_t;

  // A frame can never be shorter than its own header.
  function automatic logic [K_WIDTH-1:0] frame_len(input logic [K_WIDTH-1:0] k);
    return (k < HDR_LEN) ? HDR_LEN : k;
  endfunction
endpackage

// File: rtl/bb_header_parser_if.sv
// Serial frame input and parsed-header / data-field output bundle of the BBHEADER parser.
interface bb_header_parser_if;
  import bb_pkg::*;

  logic               bit_stream_in;
  logic               valid_in;
  logic [K_WIDTH-1:0] K_BCH;
  logic               hdr_valid;
  logic               crc_ok;
  logic               dfl_err;
  logic [15:0]        matype;
  logic [15:0]        upl;
  logic [15:0]        dfl;
  logic [7:0]         sync;
  logic [15:0]        syncd;
  logic               data_out;
  logic               data_valid;
  logic               frame_end;

  modport master (
    output bit_stream_in, valid_in, K_BCH,
    input  hdr_valid, crc_ok, dfl_err, matype, upl, dfl, sync, syncd,
    input  data_out, data_valid, frame_end
  );

  modport slave (
    input  bit_stream_in, valid_in, K_BCH,
    output hdr_valid, crc_ok, dfl_err, matype, upl, dfl, sync, syncd,
    output data_out, data_valid, frame_end
  );
endinterface

// File: rtl/bb_crc8_serial.sv
// Bit-serial CRC-8 (poly 0xD5, init 0) over the BBHEADER field bits.
// Only compiled when BBHDR_CRC_CHECK_EN is defined.
`ifdef BBHDR_CRC_CHECK_EN
module bb_crc8_serial
  import bb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_enable,
  input  logic       i_bit,
  output logic [7:0] o_crc
);
  logic [7:0] r_crc;
  logic       w_fb;

  assign w_fb = r_crc[7] ^ i_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_crc <= '0;
    end else if (i_clear) begin
      r_crc <= '0;
    end else if (i_enable) begin
      r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
    end
  end

  assign o_crc = r_crc;
endmodule
`endif

// File: rtl/bb_header_parser.sv
// DVB-S2 BBHEADER parser: extracts header fields, forwards DFL data bits, drops padding.
// Optional CRC-8 header check enabled by macro BBHDR_CRC_CHECK_EN.
module bb_header_parser
  import bb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  bb_header_parser_if.slave bus
);
  localparam int FLD_MSB = CRC_OFS - 1;

  state_t              r_state, w_state_next;
  logic [K_WIDTH-1:0]  r_cnt, w_cnt_next;
  logic [K_WIDTH-1:0]  r_len, r_dend, w_len, w_room, w_eff;
  logic [CRC_OFS-1:0]  r_fld;
  logic [15:0]         w_dfl;
  logic                w_acc, w_last, w_hdr_done, w_fwd;
  logic                r_hdr_valid, r_crc_ok, r_dfl_err, r_data_out, r_data_valid, r_frame_end;
  logic [15:0]         r_matype, r_upl, r_dfl, r_syncd;
  logic [7:0]          r_sync;

  assign w_acc      = bus.valid_in;
  assign w_len      = (r_cnt == '0) ? frame_len(bus.K_BCH) : r_len;
  assign w_last     = (r_cnt == w_len - 1'b1);
  assign w_hdr_done = w_acc && (r_state == HDR) && (r_cnt == HDR_LAST);
  assign w_dfl      = r_fld[FLD_MSB-DFL_OFS -: 16];
  assign w_room     = r_len - HDR_LEN;
  assign w_eff      = (w_dfl > w_room) ? w_room : w_dfl;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (w_acc) begin
      w_cnt_next = w_last ? '0 : r_cnt + 1'b1;
      if (w_last) begin
        w_state_next = HDR;
      end else begin
        case (r_state)
          HDR:     if (r_cnt == HDR_LAST) w_state_next = (w_eff == '0) ? PAD : DATA;
          DATA:    if (r_cnt == r_dend - 1'b1) w_state_next = PAD;
          default: w_state_next = r_state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= HDR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Only the 72 field bits are kept; the CRC byte is handled separately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fld        <= '0;
      r_len        <= '0;
      r_dend       <= '0;
      r_hdr_valid  <= 1'b0;
      r_dfl_err    <= 1'b0;
      r_data_out   <= 1'b0;
      r_data_valid <= 1'b0;
      r_frame_end  <= 1'b0;
      r_matype     <= '0;
      r_upl        <= '0;
      r_dfl        <= '0;
      r_sync       <= '0;
      r_syncd      <= '0;
    end else begin
      r_hdr_valid  <= w_hdr_done;
      r_data_valid <= w_acc && (r_state == DATA) && w_fwd;
      r_data_out   <= w_acc && (r_state == DATA) && w_fwd && bus.bit_stream_in;
      r_frame_end  <= w_acc && w_last;
      if (w_acc && (r_cnt == '0))
        r_len <= w_len;
      if (w_acc && (r_state == HDR) && (r_cnt < CRC_LEN))
        r_fld <= {r_fld[CRC_OFS-2:0], bus.bit_stream_in};
      if (w_hdr_done) begin
        r_matype  <= r_fld[FLD_MSB-MATYPE_OFS -: 16];
        r_upl     <= r_fld[FLD_MSB-UPL_OFS -: 16];
        r_dfl     <= w_dfl;
        r_sync    <= r_fld[FLD_MSB-SYNC_OFS -: 8];
        r_syncd   <= r_fld[FLD_MSB-SYNCD_OFS -: 16];
        r_dfl_err <= (w_dfl > w_room);
        r_dend    <= HDR_LEN + w_eff;
      end
    end
  end

`ifdef BBHDR_CRC_CHECK_EN
  logic [6:0] r_rx_crc;
  logic [7:0] w_crc;
  logic       w_crc_en, w_crc_clr;

  assign w_crc_en  = w_acc && (r_state == HDR) && (r_cnt < CRC_LEN);
  assign w_crc_clr = w_acc && w_last;

  bb_crc8_serial u_crc (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_crc_clr),
    .i_enable (w_crc_en),
    .i_bit    (bus.bit_stream_in),
    .o_crc    (w_crc)
  );

  // Last received CRC bit is compared straight from the input on bit 79.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_crc <= '0;
      r_crc_ok <= 1'b0;
    end else begin
      if (w_acc && (r_state == HDR) && (r_cnt >= CRC_LEN))
        r_rx_crc <= {r_rx_crc[5:0], bus.bit_stream_in};
      if (w_hdr_done)
        r_crc_ok <= ({r_rx_crc, bus.bit_stream_in} == w_crc);
    end
  end

  assign w_fwd = r_crc_ok;
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_crc_ok <= 1'b0;
    else      r_crc_ok <= 1'b1;
  end

  assign w_fwd = 1'b1;
`endif

  assign bus.hdr_valid  = r_hdr_valid;
  assign bus.crc_ok     = r_crc_ok;
  assign bus.dfl_err    = r_dfl_err;
  assign bus.matype     = r_matype;
  assign bus.upl        = r_upl;
  assign bus.dfl        = r_dfl;
  assign bus.sync       = r_sync;
  assign bus.syncd      = r_syncd;
  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.frame_end  = r_frame_end;
endmodule

// File: tb/tb_bb_header_parser.sv
// Self-checking bench for bb_header_parser: directed frames plus randomized frames against a
// frame-level reference model (CRC by polynomial long division).
module tb_bb_header_parser;
  import bb_pkg::*;

`ifdef BBHDR_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  typedef struct packed {
    logic        hv;
    logic        dv;
    logic        dout;
    logic        fe;
    logic        crc_ok;
    logic        dfl_err;
    logic [71:0] fld;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_hv = 0, n_dv = 0, n_fe = 0, hv_cyc = 0;
  int   hv0, dv0, fe0;
  exp_t exp_q[int];

  bb_header_parser_if bus();

  bb_header_parser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  // Reference CRC: remainder of M(x)*x^8 divided by x^8+x^7+x^6+x^4+x^2+1.
  function automatic logic [7:0] crc8_ref(input logic [71:0] m);
    logic [79:0] r;
    r = {m, 8'h00};
    for (int i = 79; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h1D5;
    return r[7:0];
  endfunction

  function automatic logic [71:0] mk_fld(input logic [15:0] mt, input logic [15:0] up,
                                         input logic [15:0] df, input logic [7:0] sy,
                                         input logic [15:0] sd);
    return {mt, up, df, sy, sd};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.valid_in      = 1'b0;
      bus.bit_stream_in = 1'($urandom_range(0, 1));
      bus.K_BCH         = 16'($urandom_range(0, 65535));
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst          = 1'b0;
    bus.valid_in = 1'b0;
    if (exp_q.exists(cyc)) exp_q.delete(cyc);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Drives one frame and records, per output cycle, what the parser must show.
  task automatic send_frame(input string tag, input logic [71:0] fld, input bit bad_crc,
                            input int k, input int pmode, input int gmode, input int abort_at,
                            output int start_cyc);
    logic [79:0] h;
    int   len, eff, dflv;
    bit   ok, b;
    exp_t e;
    h = {fld, crc8_ref(fld)};
    if (bad_crc) h[0] = ~h[0];
    len  = (k < 80) ? 80 : k;
    dflv = int'(fld[39:24]);
    eff  = (dflv < len - 80) ? dflv : len - 80;
    ok   = CRC_EN ? (h[7:0] == crc8_ref(fld)) : 1'b1;
    start_cyc = 0;
    $display("[TB] frame %s: K=%0d dfl=%0d data_bits=%0d crc_ok=%0b gaps=%0d abort=%0d",
             tag, k, dflv, ok ? eff : 0, ok, gmode, abort_at);
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) begin
        pulse_reset();
        return;
      end
      if (i > 0 && (gmode == 1 || (gmode == 2 && $urandom_range(0, 2) == 0))) idle(1);
      if (i < 80)          b = h[79-i];
      else if (pmode == 0) b = 1'b0;
      else if (pmode == 1) b = ((i - 80) % 2 == 0);
      else                 b = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      bus.valid_in      = 1'b1;
      bus.bit_stream_in = b;
      bus.K_BCH         = (i == 0) ? 16'(k) : 16'($urandom_range(0, 65535));
      if (i == 0) start_cyc = cyc;
      e         = '0;
      e.hv      = (i == 79);
      e.fld     = fld;
      e.crc_ok  = ok;
      e.dfl_err = (dflv > len - 80);
      e.dv      = ok && (i >= 80) && (i < 80 + eff);
      e.dout    = b;
      e.fe      = (i == len - 1);
      if (e.hv || e.dv || e.fe) exp_q[cyc+1] = e;
    end
    idle(2);
  endtask

  task automatic snap();
    hv0 = n_hv; dv0 = n_dv; fe0 = n_fe;
  endtask

  task automatic counts(input string tag, input int hv_e, input int dv_e, input int fe_e);
    chk({tag, "_hdr_pulses"},  n_hv - hv0, hv_e);
    chk({tag, "_data_pulses"}, n_dv - dv0, dv_e);
    chk({tag, "_frame_end"},   n_fe - fe0, fe_e);
  endtask

  // Per-cycle compare against the recorded expectations and held header fields.
  initial begin
    exp_t        e;
    logic [71:0] h_fld = '0;
    logic        h_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        h_fld = '0;
        h_err = 1'b0;
        chk("reset_outputs", {bus.hdr_valid, bus.crc_ok, bus.dfl_err, bus.matype, bus.upl,
                              bus.dfl, bus.sync, bus.syncd, bus.data_out, bus.data_valid,
                              bus.frame_end}, '0);
      end else begin
        if (exp_q.exists(cyc)) begin
          e = exp_q[cyc];
          exp_q.delete(cyc);
        end else begin
          e = '0;
        end
        chk("hdr_valid", bus.hdr_valid, e.hv);
        chk("data_valid", bus.data_valid, e.dv);
        chk("frame_end", bus.frame_end, e.fe);
        if (e.dv) chk("data_out", bus.data_out, e.dout);
        if (e.hv) begin
          h_fld = e.fld;
          h_err = e.dfl_err;
          chk("crc_ok", bus.crc_ok, e.crc_ok);
          hv_cyc = cyc;
        end
        chk("fields", {bus.matype, bus.upl, bus.dfl, bus.sync, bus.syncd, bus.dfl_err},
            {h_fld, h_err});
        n_hv += int'(bus.hdr_valid);
        n_dv += int'(bus.data_valid);
        n_fe += int'(bus.frame_end);
      end
    end
  end

  initial begin
    int          s;
    logic [71:0] f40, f500, fr;
    int          k, dsel, dflr;
    bus.valid_in      = 1'b0;
    bus.bit_stream_in = 1'b0;
    bus.K_BCH         = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    chk("crc_model_zero", crc8_ref(72'd0), 8'h00);
    chk("crc_model_one", crc8_ref(72'd1), 8'hD5);
    chk("crc_model_x", crc8_ref(72'd2), 8'h7F);

    snap();
    send_frame("zero_hdr", '0, 1'b0, 200, 0, 0, -1, s);
    counts("zero", 1, 0, 1);
    chk("zero_hdr_cycle", hv_cyc - s, 80);

    f40 = mk_fld(16'hF0C3, 16'd188, 16'd40, 8'h47, 16'd12);
    snap();
    send_frame("dfl40", f40, 1'b0, 200, 1, 0, -1, s);
    counts("dfl40", 1, 40, 1);

    snap();
    send_frame("dfl40_badcrc", f40, 1'b1, 200, 1, 0, -1, s);
    counts("badcrc", 1, CRC_EN ? 0 : 40, 1);

    f500 = mk_fld(16'h0001, 16'd0, 16'd500, 8'h00, 16'd0);
    snap();
    send_frame("dfl500", f500, 1'b0, 200, 2, 0, -1, s);
    counts("dfl500", 1, 120, 1);
    chk("dfl500_dfl_reg", bus.dfl, 16'd500);
    chk("dfl500_err", bus.dfl_err, 1'b1);

    snap();
    send_frame("dfl40_toggle", f40, 1'b0, 200, 1, 1, -1, s);
    counts("toggle", 1, 40, 1);

    snap();
    send_frame("abort150", f40, 1'b0, 200, 1, 0, 150, s);
    counts("abort", 1, 40, 0);
    snap();
    send_frame("after_abort", f40, 1'b0, 200, 1, 0, -1, s);
    counts("after_abort", 1, 40, 1);

    snap();
    send_frame("short_k60", mk_fld(16'h1111, 16'h2222, 16'd5, 8'h33, 16'h4444), 1'b0, 60, 2, 0, -1, s);
    counts("short", 1, 0, 1);
    chk("short_err", bus.dfl_err, 1'b1);

    snap();
    send_frame("exact_fill", mk_fld(16'hABCD, 16'h0, 16'd20, 8'h5A, 16'h7), 1'b0, 100, 2, 0, -1, s);
    counts("exact", 1, 20, 1);

    for (int n = 0; n < 20; n++) begin
      k    = $urandom_range(40, 300);
      dsel = $urandom_range(0, 3);
      if (dsel == 0)      dflr = 0;
      else if (dsel == 1) dflr = (k < 80) ? 0 : k - 80;
      else if (dsel == 2) dflr = (k < 80) ? 1 : k - 79;
      else                dflr = $urandom_range(0, 300);
      fr = mk_fld(16'($urandom), 16'($urandom), 16'(dflr), 8'($urandom), 16'($urandom));
      send_frame($sformatf("rand%0d", n), fr, ($urandom_range(0, 3) == 0), k, 2,
                 $urandom_range(0, 2), -1, s);
    end

    idle(4);
    chk("pending_expectations", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
